parallel_to_serial_wrapper: RTL and testbench
=============================================

# parallel_to_serial_wrapper

Frame serializer that loads a parallel word and shifts it out MSB-first, one bit per clock, on a single serial line. It is the transmit front end of the SD host command path (`cmd_phys`) and is also used by benches to model a card driving `PIN_CMD`. The line idles high, matching the SD CMD/DAT idle level. `complete` reports end of frame to the controlling FSM.

## Interface

Parameters:
- `WIDTH`, default 49: width of `parallel` and of the internal shift register.
- `FS_WIDTH`, default 8: width of `framesize`.

Ports:
- `Clock`, in, 1: single clock; all state changes on the rising edge.
- `Reset`, in, 1: asynchronous, active-high reset.
- `Enable`, in, 1: block enable; low forces idle and aborts any frame.
- `load_send`, in, 1: request to load `parallel` and transmit.
- `framesize`, in, FS_WIDTH: number of bits to send, counted from the MSB.
- `parallel`, in, WIDTH: frame data; bit `WIDTH-1` is sent first.
- `serial`, out, 1: serial line; registered.
- `complete`, out, 1: frame done flag; registered.

## Operation

The block is a three-state FSM: IDLE, SEND, DONE.

Reset:
- State goes to IDLE.
- `serial`=1, `complete`=0.
- Shift register and counter are cleared.

IDLE:
- Outputs: `serial`=1, `complete`=0.
- If `Enable` && `load_send`: capture `parallel` into the shift register, clear the counter, compute N = min(`framesize`, WIDTH), and go to SEND.
- If N=0, go directly to DONE instead.

SEND:
- While counter < N, each edge does all of the following:
  - `serial` <= shreg[WIDTH-1]
  - shreg <= shreg << 1 (zero fill)
  - counter++
- When counter == N, the next edge loads `serial` <= 1 and `complete` <= 1, and the FSM goes to DONE.
- `parallel` and `framesize` changes after the load edge are ignored.
- `load_send` is not sampled during SEND.

DONE:
- Outputs: `serial`=1, `complete`=1.
- Holds until `load_send`=0, then goes to IDLE and `complete` returns to 0.
- A held `load_send` does not retrigger a frame. A new frame requires `load_send` to go low and then high again.

Enable low in any state:
- The next edge returns the FSM to IDLE with `serial`=1 and `complete`=0.
- Any frame in progress is aborted.
- Enable low takes priority over all other transitions.

Reset asserted mid-frame:
- Immediate return to IDLE values.
- No partial `complete`.

## Timing

- Load edge k: IDLE to SEND. `serial` is still 1 after this edge.
- Edges k+1 .. k+N: `serial` shows parallel[WIDTH-1] .. parallel[WIDTH-N], one bit per clock.
- Edge k+N+1: `serial`=1, `complete`=1.
- Latency from the load edge to the first data bit is 1 cycle.
- The frame occupies exactly N cycles.
- `complete` rises one cycle after the last bit.
- With N=0, `complete` rises at edge k+1 and `serial` stays 1 throughout.

## Structure

Shared package (`definitions`):
- State encoding for IDLE, SEND, DONE.
- Default `WIDTH`=49 and `FS_WIDTH`=8.
- SD idle-line level constant (1).

Sub-module:
- `counter`: a generic up-counter with synchronous clear and enable, width FS_WIDTH, the same one used elsewhere in the PHY blocks.
- The wrapper instantiates `counter` and holds the FSM, shift register and output registers.

## Test plan

1. Reset: assert `Reset` mid-frame, asynchronously -> `serial`=1 and `complete`=0 immediately; FSM in IDLE.
2. SD command frame: WIDTH=49, `framesize`=49, `parallel`={2'b0, 6'd7, 32'd789, 9'b1}, pulse `Enable`+`load_send` high for many cycles ->
   - `serial` emits 00 000111, then 789 as 32 bits MSB-first, then 000000001.
   - `complete`=1 at load+50 and holds while `load_send` is high.
   - `complete`=0 one edge after `load_send` falls.
   - Only one frame is sent.
3. Short frame: `framesize`=8 with the same data -> the 8 MSBs are sent (0,0,0,0,0,1,1,1), then `serial`=1 and `complete`=1 at load+9.
4. Abort: drop `Enable` at the 20th bit -> next edge `serial`=1, `complete`=0, FSM in IDLE; a later request sends a fresh full frame.
5. Boundaries:
   - `framesize`=0 -> `complete` at load+1 and no data bits.
   - `framesize`=200 -> clamped to 49 bits.
   - Enable=0 with `load_send`=1 -> nothing is sent.

Source files
------------

// File: rtl/definitions.sv
// Shared PHY definitions: serializer state encoding, default widths and the
// SD bus idle-line level.
package definitions;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int DEF_WIDTH    = 49;
   localparam int DEF_FS_WIDTH = 8;

   // CMD/DAT lines idle high between frames.
   localparam logic SD_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/counter.sv
// Generic up-counter with synchronous clear (priority) and count enable,
// shared by the PHY blocks.
module counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/parallel_to_serial_wrapper.sv
// MSB-first frame serializer for the SD command path. Loads a parallel word,
// shifts min(framesize, WIDTH) bits onto a high-idling line, then flags complete.
module parallel_to_serial_wrapper
   import definitions::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int FS_WIDTH = DEF_FS_WIDTH
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic                Enable,
   input  logic                load_send,
   input  logic [FS_WIDTH-1:0] framesize,
   input  logic [WIDTH-1:0]    parallel,
   output logic                serial,
   output logic                complete,
   output state_t              state_dbg
);

   state_t              state, state_nx;
   logic [WIDTH-1:0]    shreg;
   logic [FS_WIDTH-1:0] n_reg, n_load, cnt;
   logic                serial_nx, complete_nx;
   logic                load, shift, cnt_clr, cnt_en;

   // Frame length is latched at the load edge so later framesize changes are ignored.
   always_comb begin
      if (32'(framesize) > 32'(WIDTH)) begin
         n_load = FS_WIDTH'(WIDTH);
      end else begin
         n_load = framesize;
      end
   end

   counter #(.W(FS_WIDTH)) u_counter (
      .clk   (Clock),
      .rst   (Reset),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .count (cnt)
   );

   always_comb begin
      state_nx    = state;
      serial_nx   = SD_IDLE_LEVEL;
      complete_nx = 1'b0;
      load        = 1'b0;
      shift       = 1'b0;
      cnt_clr     = 1'b0;
      cnt_en      = 1'b0;
      if (!Enable) begin
         state_nx = ST_IDLE;
         cnt_clr  = 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               if (load_send) begin
                  load     = 1'b1;
                  cnt_clr  = 1'b1;
                  state_nx = (n_load == '0) ? ST_DONE : ST_SEND;
               end
            end
            ST_SEND: begin
               if (cnt < n_reg) begin
                  serial_nx = shreg[WIDTH-1];
                  shift     = 1'b1;
                  cnt_en    = 1'b1;
               end else begin
                  complete_nx = 1'b1;
                  state_nx    = ST_DONE;
               end
            end
            ST_DONE: begin
               // Level-held load_send must drop before another frame can start.
               if (load_send) begin
                  complete_nx = 1'b1;
               end else begin
                  state_nx = ST_IDLE;
               end
            end
            default: state_nx = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state    <= ST_IDLE;
         serial   <= SD_IDLE_LEVEL;
         complete <= 1'b0;
         shreg    <= '0;
         n_reg    <= '0;
      end else begin
         state    <= state_nx;
         serial   <= serial_nx;
         complete <= complete_nx;
         if (load) begin
            shreg <= parallel;
            n_reg <= n_load;
         end else if (shift) begin
            shreg <= shreg << 1;
         end
      end
   end

   assign state_dbg = state;

endmodule

// File: tb/tb_parallel_to_serial_wrapper.sv
// Randomized self-checking bench for parallel_to_serial_wrapper; expected line
// values come from a per-cycle frame model derived from the timing rules.
module tb_parallel_to_serial_wrapper;
   import definitions::*;

   localparam int WIDTH    = 49;
   localparam int FS_WIDTH = 8;

   logic                Clock = 1'b0;
   logic                Reset;
   logic                Enable;
   logic                load_send;
   logic [FS_WIDTH-1:0] framesize;
   logic [WIDTH-1:0]    parallel;
   logic                serial;
   logic                complete;
   state_t              state_dbg;

   int checks = 0;
   int errors = 0;

   logic [WIDTH-1:0] sd_cmd;

   parallel_to_serial_wrapper #(.WIDTH(WIDTH), .FS_WIDTH(FS_WIDTH)) dut (
      .Clock     (Clock),
      .Reset     (Reset),
      .Enable    (Enable),
      .load_send (load_send),
      .framesize (framesize),
      .parallel  (parallel),
      .serial    (serial),
      .complete  (complete),
      .state_dbg (state_dbg)
   );

   // ---------------- clock / reset ----------------
   always #5 Clock = ~Clock;

   // ---------------- driver: one frame with per-cycle model ----------------
   // Model: after load edge k+j, j=0 -> line 1; 1..N -> data[WIDTH-j]; >N -> line 1, complete 1.
   task automatic send_frame(input logic [WIDTH-1:0] data, input logic [FS_WIDTH-1:0] fs,
                             input int hold, input string name);
      int   n;
      logic exp_s, exp_c;
      n = (int'(fs) > WIDTH) ? WIDTH : int'(fs);
      @(negedge Clock);
      parallel  = data;
      framesize = fs;
      Enable    = 1'b1;
      load_send = 1'b1;
      for (int j = 0; j <= n + hold; j++) begin
         @(negedge Clock);
         if (j == 0) begin
            parallel  = WIDTH'({$urandom(), $urandom()});
            framesize = FS_WIDTH'($urandom());
         end
         if (j == 0) begin
            exp_s = 1'b1; exp_c = 1'b0;
         end else if (j <= n) begin
            exp_s = data[WIDTH-j]; exp_c = 1'b0;
         end else begin
            exp_s = 1'b1; exp_c = 1'b1;
         end
         checks++;
         if (serial !== exp_s || complete !== exp_c) begin
            errors++;
            $display("FAIL %s cycle %0d: serial=%b complete=%b, expected serial=%b complete=%b",
                     name, j, serial, complete, exp_s, exp_c);
         end
      end
      load_send = 1'b0;
      @(negedge Clock);
      checks++;
      if (serial !== 1'b1 || complete !== 1'b0 || state_dbg !== ST_IDLE) begin
         errors++;
         $display("FAIL %s release: serial=%b complete=%b state=%0d, expected 1 0 %0d",
                  name, serial, complete, state_dbg, ST_IDLE);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      checks++;
      if (serial !== 1'b1 || complete !== 1'b0 || state_dbg !== ST_IDLE) begin
         errors++;
         $display("FAIL reset_init: serial=%b complete=%b state=%0d, expected 1 0 %0d",
                  serial, complete, state_dbg, ST_IDLE);
      end
      Reset = 1'b0;
      // All-zero frame so the line is low when reset hits mid-frame.
      @(negedge Clock);
      parallel = '0; framesize = 8'd49; Enable = 1'b1; load_send = 1'b1;
      repeat (6) @(negedge Clock);
      checks++;
      if (serial !== 1'b0 || state_dbg !== ST_SEND) begin
         errors++;
         $display("FAIL reset_preframe: serial=%b state=%0d, expected 0 %0d",
                  serial, state_dbg, ST_SEND);
      end
      #2 Reset = 1'b1;
      #1;
      checks++;
      if (serial !== 1'b1 || complete !== 1'b0 || state_dbg !== ST_IDLE) begin
         errors++;
         $display("FAIL reset_async: serial=%b complete=%b state=%0d, expected 1 0 %0d",
                  serial, complete, state_dbg, ST_IDLE);
      end
      Enable = 1'b0; load_send = 1'b0;
      @(negedge Clock);
      Reset = 1'b0;
      @(negedge Clock);
      checks++;
      if (serial !== 1'b1 || complete !== 1'b0 || state_dbg !== ST_IDLE) begin
         errors++;
         $display("FAIL reset_release: serial=%b complete=%b state=%0d, expected 1 0 %0d",
                  serial, complete, state_dbg, ST_IDLE);
      end
   endtask

   task automatic test_sd_frame;
      send_frame(sd_cmd, 8'd49, 5, "sd_full");
   endtask

   task automatic test_short_frame;
      send_frame(sd_cmd, 8'd8, 3, "sd_short");
   endtask

   task automatic test_boundaries;
      send_frame(sd_cmd, 8'd0, 3, "fs_zero");
      send_frame(WIDTH'({$urandom(), $urandom()}), 8'd200, 2, "fs_clamp");
      send_frame(WIDTH'({$urandom(), $urandom()}), 8'd1, 2, "fs_one");
      // Enable low with a pending request: line must stay idle.
      @(negedge Clock);
      parallel = '0; framesize = 8'd49; Enable = 1'b0; load_send = 1'b1;
      for (int j = 0; j < 6; j++) begin
         @(negedge Clock);
         checks++;
         if (serial !== 1'b1 || complete !== 1'b0 || state_dbg !== ST_IDLE) begin
            errors++;
            $display("FAIL disabled cycle %0d: serial=%b complete=%b state=%0d, expected 1 0 %0d",
                     j, serial, complete, state_dbg, ST_IDLE);
         end
      end
      load_send = 1'b0; Enable = 1'b1;
   endtask

   task automatic test_abort;
      @(negedge Clock);
      parallel = sd_cmd; framesize = 8'd49; Enable = 1'b1; load_send = 1'b1;
      for (int j = 0; j <= 20; j++) begin
         @(negedge Clock);
         if (j >= 1) begin
            checks++;
            if (serial !== sd_cmd[WIDTH-j] || complete !== 1'b0) begin
               errors++;
               $display("FAIL abort_bits cycle %0d: serial=%b complete=%b, expected %b 0",
                        j, serial, complete, sd_cmd[WIDTH-j]);
            end
         end
      end
      Enable = 1'b0;
      @(negedge Clock);
      checks++;
      if (serial !== 1'b1 || complete !== 1'b0 || state_dbg !== ST_IDLE) begin
         errors++;
         $display("FAIL abort: serial=%b complete=%b state=%0d, expected 1 0 %0d",
                  serial, complete, state_dbg, ST_IDLE);
      end
      load_send = 1'b0;
      @(negedge Clock);
      Enable = 1'b1;
      send_frame(sd_cmd, 8'd49, 2, "after_abort");
   endtask

   task automatic test_random;
      for (int f = 0; f < 10; f++) begin
         send_frame(WIDTH'({$urandom(), $urandom()}), FS_WIDTH'($urandom_range(0, 70)),
                    $urandom_range(1, 4), "random");
      end
   endtask

   task automatic test_back_to_back;
      send_frame(WIDTH'({$urandom(), $urandom()}), 8'd12, 1, "b2b_a");
      send_frame(WIDTH'({$urandom(), $urandom()}), 8'd12, 1, "b2b_b");
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      sd_cmd    = {2'b0, 6'd7, 32'd789, 9'b1};
      Reset     = 1'b1;
      Enable    = 1'b0;
      load_send = 1'b0;
      framesize = '0;
      parallel  = '0;
      repeat (2) @(negedge Clock);
      test_reset();
      test_sd_frame();
      test_short_frame();
      test_abort();
      test_boundaries();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
